prog_mem: RTL

PROG_MEM -- requirements
Module: prog_mem

---
 rtl/prog_mem_pkg.sv | 23 ++
 rtl/prog_mem_erase_seq.sv | 78 +++++++
 rtl/prog_mem.sv | 124 ++++++++++++
 3 files changed

// File: rtl/prog_mem_pkg.sv
// ============================================================================
// Module : prog_mem_pkg
// Brief  : Shared defaults and erase-sequencer state encoding for prog_mem.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package prog_mem_pkg;

  localparam int unsigned ROM_NUM   = 4096;
  localparam int unsigned PM_DATA_W = 32;
  localparam int unsigned PM_ADDR_W = 32;
  localparam logic [PM_DATA_W-1:0] PM_ERASE_VAL = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DONE  = 2'd2
  } erase_state_e;

endpackage : prog_mem_pkg

`default_nettype wire

// File: rtl/prog_mem_erase_seq.sv
// ============================================================================
// Module : prog_mem_erase_seq
// Brief  : Whole-array erase sequencer, one word per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_mem_erase_seq
  import prog_mem_pkg::*;
#(
  parameter int unsigned DEPTH = ROM_NUM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     we_o,
  output logic [$clog2(DEPTH)-1:0] idx_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  erase_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    we_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ERASE;
          cnt_d   = '0;
        end
      end
      ST_ERASE: begin
        busy_o = 1'b1;
        we_o   = 1'b1;
        // Counter parks on the last index instead of wrapping.
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign idx_o = cnt_q;

endmodule : prog_mem_erase_seq

`default_nettype wire

// File: rtl/prog_mem.sv
// ============================================================================
// Module : prog_mem
// Brief  : Byte-enabled program memory with registered read and bulk erase.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int unsigned       DATA_W    = PM_DATA_W,
  parameter int unsigned       ADDR_W    = PM_ADDR_W,
  parameter int unsigned       DEPTH     = ROM_NUM,
  parameter logic [DATA_W-1:0] ERASE_VAL = {DATA_W{1'b1}},
  parameter                    INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                erase_en,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                rd_valid_o,
  output logic                busy_o,
  output logic                erase_done_o,
  output logic                addr_err_o
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] data_q;
  logic              rd_valid_q;
  logic              addr_err_q;

  logic              seq_busy, seq_done, seq_we;
  logic [IDX_W-1:0]  seq_idx;

  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              wr_in_range, rd_in_range;
  logic              user_ok, wr_acc, rd_acc, addr_err_d;
  logic              erase_we;
  logic [DATA_W-1:0] rd_word;
  logic              unused_addr_lsbs;

  assign wr_idx = wr_addr_i[IDX_W+1:2];
  assign rd_idx = rd_addr_i[IDX_W+1:2];
  assign unused_addr_lsbs = ^{wr_addr_i[1:0], rd_addr_i[1:0]};

  generate
    if (ADDR_W - 2 > IDX_W) begin : g_range_chk
      assign wr_in_range = (wr_addr_i[ADDR_W-1:IDX_W+2] == '0);
      assign rd_in_range = (rd_addr_i[ADDR_W-1:IDX_W+2] == '0);
    end else begin : g_range_full
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end
  endgenerate

  prog_mem_erase_seq #(
    .DEPTH (DEPTH)
  ) u_erase_seq (
    .clk     (clk),
    .rst     (rst),
    .start_i (erase_en),
    .busy_o  (seq_busy),
    .done_o  (seq_done),
    .we_o    (seq_we),
    .idx_o   (seq_idx)
  );

  assign user_ok    = ~rst & ~seq_busy;
  assign wr_acc     = wr_en_i & user_ok & wr_in_range;
  assign rd_acc     = rd_en_i & user_ok;
  assign addr_err_d = user_ok & ((wr_en_i & ~wr_in_range) | (rd_en_i & ~rd_in_range));
  assign erase_we   = seq_we & ~rst;

  // Same-word write bytes are forwarded so the read sees the merged word.
  always_comb begin
    rd_word = mem_q[rd_idx];
    if (wr_acc && (wr_idx == rd_idx)) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be_i[b]) rd_word[8*b +: 8] = data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (erase_we) begin
      mem_q[seq_idx] <= ERASE_VAL;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be_i[b]) mem_q[wr_idx][8*b +: 8] <= data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      addr_err_q <= addr_err_d;
      if (rd_acc) data_q <= rd_in_range ? rd_word : '0;
    end
  end

  assign data_o       = rst ? '0 : data_q;
  assign rd_valid_o   = rd_valid_q & ~rst;
  assign addr_err_o   = addr_err_q & ~rst;
  assign busy_o       = seq_busy & ~rst;
  assign erase_done_o = seq_done & ~rst;

endmodule : prog_mem

`default_nettype wire
